reg_file_sb: RTL and testbench

- Parametrised successor to the MIPS general-purpose register file. It provides NUM_RD combinational read ports and one write port, with optional write-to-read bypass.
- Adds a per-register scoreboard that counts in-flight writes, so the ID stage can detect RAW hazards and stall.
- Sits between the ID stage (reads, issue) and the WB stage (writes).

---
 rtl/reg_file_sb.sv | 94 +++++++++
 tb/tb_reg_file_sb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD combinational read ports, one write port, optional write bypass,
// and a per-register in-flight write scoreboard; reads are zero latency, issue stalls via issue_ready.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  input  logic                       flush
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];

  // One-hot decodes of the issue and writeback targets; register 0 never matches.
  logic [DEPTH-1:0] iss_hit;
  logic [DEPTH-1:0] wr_hit;

  assign iss_hit = (issue_en && (issue_addr != '0)) ? (DEPTH'(1) << issue_addr) : '0;
  assign wr_hit  = (wr_en && (wr_addr != '0)) ? (DEPTH'(1) << wr_addr) : '0;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_hit != '0) begin
      regs_d[wr_addr] = wr_data;
    end
    for (int r = 1; r < DEPTH; r++) begin
      if (flush) begin
        cnt_d[r] = '0;
      end else if (iss_hit[r] && wr_hit[r]) begin
        cnt_d[r] = cnt_q[r];
      end else if (iss_hit[r]) begin
        if (cnt_q[r] != CNT_MAX) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (wr_hit[r]) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // A same-cycle write to a register with exactly one write outstanding retires the hazard now.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              active;
    logic              hit;
    logic [CNT_W-1:0]  pend;

    assign ra     = rd_addr[gi*ADDR_W +: ADDR_W];
    assign active = rst && rd_en[gi] && (ra != '0);
    assign hit    = (BYPASS != 0) && wr_en && (wr_addr == ra);
    assign pend   = cnt_q[ra];

    assign rd_data[gi*DATA_W +: DATA_W] = !active ? '0 : (hit ? wr_data : regs_q[ra]);
    assign rd_busy[gi] = active && (pend != '0) && !(hit && (pend == CNT_ONE));
  end

  assign issue_ready = (issue_addr == '0) || (cnt_q[issue_addr] != CNT_MAX);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared every cycle against an array/count model, plus literal spot values.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;

  logic [63:0] rd_data_b1, rd_data_b0;
  logic [1:0]  rd_busy_b1, rd_busy_b0;
  logic        issue_ready_b1, issue_ready_b0;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] mreg [32];
  int          mcnt [32];

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(2), .BYPASS(1)) u_b1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready_b1), .flush(flush)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(2), .BYPASS(0)) u_b0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready_b0), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural values plus the number of writes still owed to each register.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        mreg[r] = 32'h0;
        mcnt[r] = 0;
      end
    end else begin
      bit iss, wrt;
      iss = issue_en && (issue_addr != 5'd0);
      wrt = wr_en && (wr_addr != 5'd0);
      if (wrt) mreg[wr_addr] = wr_data;
      if (flush) begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
      end else if (!(iss && wrt && issue_addr == wr_addr)) begin
        if (iss && mcnt[issue_addr] < 3) mcnt[issue_addr] = mcnt[issue_addr] + 1;
        if (wrt && mcnt[wr_addr] > 0) mcnt[wr_addr] = mcnt[wr_addr] - 1;
      end
    end
  end

  function automatic logic [31:0] exp_data(input int p, input bit byp);
    logic [4:0] a;
    a = rd_addr[p*5 +: 5];
    if (!rst || !rd_en[p] || a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int p, input bit byp);
    logic [4:0] a;
    int owed;
    a = rd_addr[p*5 +: 5];
    if (!rst || !rd_en[p] || a == 5'd0) return 1'b0;
    owed = mcnt[a];
    if (byp && wr_en && wr_addr == a && owed > 0) owed = owed - 1;
    return owed != 0;
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      check($sformatf("b1_rd_data%0d", p), {32'h0, rd_data_b1[p*32 +: 32]}, {32'h0, exp_data(p, 1'b1)});
      check($sformatf("b0_rd_data%0d", p), {32'h0, rd_data_b0[p*32 +: 32]}, {32'h0, exp_data(p, 1'b0)});
      check($sformatf("b1_rd_busy%0d", p), {63'h0, rd_busy_b1[p]}, {63'h0, exp_busy(p, 1'b1)});
      check($sformatf("b0_rd_busy%0d", p), {63'h0, rd_busy_b0[p]}, {63'h0, exp_busy(p, 1'b0)});
    end
    check("b1_issue_ready", {63'h0, issue_ready_b1}, {63'h0, (issue_addr == 5'd0) || (mcnt[issue_addr] < 3)});
    check("b0_issue_ready", {63'h0, issue_ready_b0}, {63'h0, (issue_addr == 5'd0) || (mcnt[issue_addr] < 3)});
  end

  task automatic set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                     input logic ie, input logic [4:0] ia, input logic fl);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = {a1, a0};
    issue_en = ie; issue_addr = ia; flush = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set(1, 5'd3, 32'hDEADBEEF, 2'b11, 5'd3, 5'd3, 0, 5'd0, 0);
    @(negedge clk);
    check("rst_rd_data", {32'h0, rd_data_b1[31:0]}, 64'h0);
    check("rst_rd_busy", {62'h0, rd_busy_b1}, 64'h0);
    nxt();

    rst = 1'b1;
    set(0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd0, 0, 5'd0, 0);
    @(negedge clk); check("no_write_in_rst", {32'h0, rd_data_b1[31:0]}, 64'h0); nxt();

    set(1, 5'd0, 32'h1234, 2'b01, 5'd0, 5'd0, 0, 5'd0, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 0, 5'd0, 0);
    @(negedge clk); check("reg0_zero", {32'h0, rd_data_b1[31:0]}, 64'h0); nxt();

    set(1, 5'd5, 32'h11111111, 2'b00, 5'd0, 5'd0, 0, 5'd0, 0); @(negedge clk); nxt();
    set(1, 5'd5, 32'hA5A5A5A5, 2'b11, 5'd5, 5'd5, 0, 5'd0, 0);
    @(negedge clk);
    check("bypass_p0", {32'h0, rd_data_b1[31:0]}, 64'hA5A5A5A5);
    check("bypass_p1", {32'h0, rd_data_b1[63:32]}, 64'hA5A5A5A5);
    check("nobypass_p0", {32'h0, rd_data_b0[31:0]}, 64'h11111111);
    nxt();

    set(0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1, 5'd7, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 0, 5'd0, 0);
    @(negedge clk); check("r7_busy", {63'h0, rd_busy_b1[0]}, 64'h1); nxt();
    set(1, 5'd7, 32'h42, 2'b01, 5'd7, 5'd0, 0, 5'd0, 0);
    @(negedge clk);
    check("r7_wb_busy", {63'h0, rd_busy_b1[0]}, 64'h0);
    check("r7_wb_data", {32'h0, rd_data_b1[31:0]}, 64'h42);
    check("r7_wb_busy_nobyp", {63'h0, rd_busy_b0[0]}, 64'h1);
    nxt();
    set(0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 0, 5'd0, 0);
    @(negedge clk); check("r7_after", {63'h0, rd_busy_b1[0]}, 64'h0); nxt();

    for (int k = 0; k < 3; k++) begin
      set(0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1, 5'd9, 0); @(negedge clk); nxt();
    end
    set(0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 0, 5'd9, 0);
    @(negedge clk); check("r9_ready_sat", {63'h0, issue_ready_b1}, 64'h0); nxt();
    set(0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1, 5'd9, 0); @(negedge clk); nxt();
    for (int k = 0; k < 3; k++) begin
      set(1, 5'd9, 32'h100 + k, 2'b10, 5'd0, 5'd9, 0, 5'd0, 0);
      @(negedge clk);
      check($sformatf("r9_wb%0d_busy", k), {63'h0, rd_busy_b1[1]}, (k < 2) ? 64'h1 : 64'h0);
      nxt();
    end
    set(0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 0, 5'd9, 0);
    @(negedge clk); check("r9_final_data", {32'h0, rd_data_b1[63:32]}, 64'h102); nxt();

    set(0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0); @(negedge clk); nxt();
    set(1, 5'd4, 32'h44, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 0, 5'd0, 0);
    @(negedge clk); check("r4_still_busy", {63'h0, rd_busy_b1[0]}, 64'h1); nxt();
    set(1, 5'd4, 32'h45, 2'b00, 5'd0, 5'd0, 0, 5'd0, 0); @(negedge clk); nxt();

    for (int k = 0; k < 2; k++) begin
      set(0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1, 5'd2, 0); @(negedge clk); nxt();
    end
    set(0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1, 5'd8, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b11, 5'd2, 5'd8, 1, 5'd2, 1); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b11, 5'd2, 5'd8, 0, 5'd0, 0);
    @(negedge clk); check("flush_busy", {62'h0, rd_busy_b1}, 64'h0); nxt();
    set(1, 5'd2, 32'h77, 2'b00, 5'd0, 5'd0, 0, 5'd0, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0, 1, 5'd0, 0);
    @(negedge clk);
    check("r2_post_flush_data", {32'h0, rd_data_b1[31:0]}, 64'h77);
    check("r2_post_flush_busy", {63'h0, rd_busy_b1[0]}, 64'h0);
    check("issue_r0_ready", {63'h0, issue_ready_b1}, 64'h1);
    nxt();

    set(1, 5'd11, 32'hBB, 2'b00, 5'd0, 5'd0, 1, 5'd10, 0); @(negedge clk); nxt();
    set(0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 0, 5'd0, 0);
    @(negedge clk);
    check("pre_rst_busy", {63'h0, rd_busy_b1[0]}, 64'h1);
    check("pre_rst_data", {32'h0, rd_data_b1[63:32]}, 64'hBB);
    #2 rst = 1'b0;
    #1 check("mid_rst_data", rd_data_b1, 64'h0);
    check("mid_rst_busy", {62'h0, rd_busy_b1}, 64'h0);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {62'h0, rd_busy_b1}, 64'h0);
    check("post_rst_data", rd_data_b1, 64'h0);
    nxt();

    for (int i = 1; i < 32; i++) begin
      set(1, 5'(i), 32'h01010101 * i, 2'b11, 5'(i), 5'(i - 1), 1, 5'((i * 7) % 32), 0);
      @(negedge clk); nxt();
    end
    for (int i = 0; i < 32; i += 2) begin
      set(0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(i + 1), 0, 5'(i), 0);
      @(negedge clk); nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
